// File: rtl/fast_adder_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one N-bit parallel-prefix adder is reused across
// WORDS slices, LSB slice first, with the inter-slice carry held in a register.
module fast_adder_seq_ctrl #(
   parameter int unsigned N     = 10,
   parameter int unsigned WORDS = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [N*WORDS-1:0] op_a,
   input  logic [N*WORDS-1:0] op_b,
   input  logic               cin,
   input  logic               sub,
   output logic               busy,
   output logic               done,
   output logic [N*WORDS-1:0] sum,
   output logic               cout,
   output logic               ovf
);

   localparam int unsigned W    = N * WORDS;
   localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e          state_q, state_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            cout_q, cout_d;
   logic            ovf_q, ovf_d;

   logic [31:0]     slice_base;
   logic [N-1:0]    add_a, add_b, add_res;
   logic            add_cout;
   logic [N-1:0]    p0, g_v, p_v, g_n, p_n;

   // idx never leaves 0..WORDS-1, so the adder operands are always real register bits.
   assign slice_base = 32'(idx_q) * N;
   assign add_a      = a_q[slice_base +: N];
   assign add_b      = b_q[slice_base +: N];

   // Kogge-Stone prefix adder; the slice carry-in is folded into bit 0's generate term.
   always_comb begin
      p0       = add_a ^ add_b;
      g_v      = add_a & add_b;
      g_v[0]   = g_v[0] | (p0[0] & carry_q);
      p_v      = p0;
      g_n      = g_v;
      p_n      = p_v;
      for (int d = 1; d < int'(N); d = d * 2) begin
         for (int i = 0; i < int'(N); i++) begin
            if (i >= d) begin
               g_n[i] = g_v[i] | (p_v[i] & g_v[i-d]);
               p_n[i] = p_v[i] & p_v[i-d];
            end else begin
               g_n[i] = g_v[i];
               p_n[i] = p_v[i];
            end
         end
         g_v = g_n;
         p_v = p_n;
      end
      add_res  = p0 ^ {g_v[N-2:0], carry_q};
      add_cout = g_v[N-1];
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = op_a;
               b_d     = sub ? ~op_b : op_b;
               carry_d = sub ? 1'b1 : cin;
               idx_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               ovf_d   = 1'b0;
               state_d = StRun;
            end
         end
         StRun: begin
            sum_d[slice_base +: N] = add_res;
            carry_d                = add_cout;
            if (idx_q == LastIdx) begin
               cout_d  = add_cout;
               ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_res[N-1] != a_q[W-1]);
               state_d = StDone;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = (state_q != StIdle);
   assign done = (state_q == StDone);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule
